dmem_responder: RTL and testbench
=================================

// Module: dmem_responder
// PURPOSE
//   Data-memory responder for the pipelined MIPS core's M-stage port: serves the
//   core's 32-bit load/store requests (address, write data, 4-bit byte-lane write
//   strobe) from an internal word array. Inserts WAIT_CYCLES of latency and drives
//   a stall back to the hazard logic. It is the slave end of the core's data bus.
// PARAMETERS
//   ADDR_W       8   word-address width; array depth = 2**ADDR_W 32-bit words
//   WAIT_CYCLES  2   cycles stall is held per request (0..15); 0 = no stall
// PORTS
//   clk      in   1   clock, rising edge
//   rst      in   1   asynchronous, active-low reset
//   req      in   1   request valid (load or store) from M stage
//   addr     in   32  byte address; word index = addr[ADDR_W+1:2]
//   wdata    in   32  store data, byte lane i = wdata[8i+7:8i]
//   wen      in   4   byte-lane write strobe; 4'b0000 = load
//   rdata    out  32  load data, valid in the cycle stall is low at completion
//   stall    out  1   hold M stage and everything upstream
//   addr_err out  1   misaligned access flag (DMEM_ALIGN_CHK_EN only)
// BEHAVIOUR
//   - Reset (rst=0, async): state=IDLE, counter=0, latched req cleared, stall=0,
//     rdata=0, addr_err=0. Array contents are NOT reset.
//   - FSM: IDLE -> WAIT -> DONE -> IDLE.
//     IDLE: req=1 and WAIT_CYCLES>0 -> latch addr/wdata/wen, counter=WAIT_CYCLES-1,
//       go WAIT; stall=1 combinationally in this accept cycle.
//     WAIT: stall=1; counter decrements; at 0 go DONE.
//     DONE: stall=0; rdata = array[latched word] with latched wen lanes merged from
//       latched wdata (write-first); store commits at this rising edge; -> IDLE.
//   - Latency: request accepted in cycle t -> stall high t..t+N-1, low at t+N
//     (N=WAIT_CYCLES). DONE never accepts a new request; the next one is seen at t+N+1.
//   - WAIT_CYCLES=0: FSM bypassed; stall tied 0; rdata combinational from live
//     addr (write-first merge); store commits at the edge of the req cycle.
//   - Loads never modify the array. req=0 in IDLE: rdata=0.
//   - Address bits above ADDR_W+1 ignored (aliasing wrap). addr[1:0] ignored
//     unless the alignment check is compiled in.
//   - Live inputs are ignored after acceptance (latched copy used).
//   - Reset mid-WAIT aborts: pending store is dropped, stall drops immediately.
// CONFIGURATION
//   DMEM_ALIGN_CHK_EN defined: in the accept/DONE path, legal strobes are 4'b1111
//     with addr[1:0]=0, 4'b0011/4'b1100 with addr[0]=0, single-bit with
//     lane==addr[1:0], and loads with any addr (the core aligns the load). Illegal
//     -> addr_err=1 for the DONE cycle (or the req cycle if N=0), store suppressed.
//   Undefined: addr_err tied 0; every strobe pattern is written as given.
// STRUCTURE
//   dmem_pkg: FSM state encoding (IDLE/WAIT/DONE), WEN_NONE/WEN_WORD/WEN_HALF_LO/
//     WEN_HALF_HI constants, function for the byte-lane merge.
//   Sub-module dmem_bank: 2**ADDR_W x 32 array, 4 byte-lane write enables,
//     async read port; the responder holds the FSM, counter, latches and checks.
// TESTING
//   1 N=2: store 0xDEADBEEF, wen=4'hF, addr 0x10 -> stall high 2 cycles, low 3rd;
//     then load 0x10 -> rdata=0xDEADBEEF in the cycle stall drops.
//   2 Byte lanes: word 0x20=0x11223344; store 0x000000AA wen=4'b0001 -> load
//     returns 0x112233AA; wen=4'b1100 data 0xBBCC0000 -> 0xBBCC33AA.
//   3 Back-to-back: store then load same address, req held high -> second accept
//     at t+N+1, load returns the new data; no missed or duplicated accepts.
//   4 Reset pulse during WAIT of store 0x55555555 to 0x30 -> stall=0 and rdata=0
//     at once; later load 0x30 returns the prior contents.
//   5 Aliasing: ADDR_W=8, store 0x12345678 at 0x400 -> load 0x000 returns 0x12345678.
//   6 DMEM_ALIGN_CHK_EN: store wen=4'hF addr 0x42 -> addr_err=1 in DONE, word
//     unchanged; wen=4'b0100 addr 0x42 -> addr_err=0, byte 2 written.
//     Also run with N=0: stall stays 0 throughout.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared constants, FSM encoding and byte-lane helpers for the data-memory responder.
package dmem_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned LANES  = 4;
    localparam int unsigned CNT_W  = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [LANES-1:0] WEN_NONE    = 4'b0000;
    localparam logic [LANES-1:0] WEN_WORD    = 4'b1111;
    localparam logic [LANES-1:0] WEN_HALF_LO = 4'b0011;
    localparam logic [LANES-1:0] WEN_HALF_HI = 4'b1100;

    // Replace the strobed byte lanes of old_word with the matching lanes of new_data.
    function automatic logic [DATA_W-1:0] lane_merge(
        input logic [DATA_W-1:0] old_word,
        input logic [DATA_W-1:0] new_data,
        input logic [LANES-1:0]  wen
    );
        logic [DATA_W-1:0] res;
        res = old_word;
        for (int i = 0; i < LANES; i++) begin
            if (wen[i]) begin
                res[8*i +: 8] = new_data[8*i +: 8];
            end
        end
        return res;
    endfunction

    // Loads are always legal; stores must sit on their natural boundary.
    function automatic logic align_ok(input logic [LANES-1:0] wen, input logic [1:0] lo);
        case (wen)
            WEN_NONE:                 return 1'b1;
            WEN_WORD:                 return (lo == 2'b00);
            WEN_HALF_LO, WEN_HALF_HI: return !lo[0];
            4'b0001, 4'b0010,
            4'b0100, 4'b1000:         return wen[lo];
            default:                  return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/dmem_bank.sv
// Word-addressed 32-bit storage with per-byte write enables and an async read port.
module dmem_bank
    import dmem_pkg::*;
#(
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] idx,
    input  logic [LANES-1:0]  we,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    // Contents are deliberately left unreset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < LANES; i++) begin
            if (we[i]) begin
                mem[idx][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    assign rdata = mem[idx];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder for the M-stage port: serves loads/stores with WAIT_CYCLES of stall.
// Optional misaligned-store check is compiled in with DMEM_ALIGN_CHK_EN.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic [31:0]       addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [LANES-1:0]  wen,
    output logic [DATA_W-1:0] rdata,
    output logic              stall,
    output logic              addr_err
);

    localparam int unsigned      IDX_HI   = ADDR_W + 1;
    localparam bit               BYPASS   = (WAIT_CYCLES == 0);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic              accept;
    logic              req_live;
    logic [ADDR_W-1:0] lat_idx, bank_idx;
    logic [DATA_W-1:0] lat_wdata, bank_wdata, bank_rdata;
    logic [LANES-1:0]  lat_wen, cur_wen, bank_we;
    logic              chk_err;
    logic              unused_addr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Request latch: live inputs are ignored once a request is accepted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lat_idx   <= '0;
            lat_wdata <= '0;
            lat_wen   <= WEN_NONE;
        end else if (accept) begin
            lat_idx   <= addr[IDX_HI:2];
            lat_wdata <= wdata;
            lat_wen   <= wen;
        end
    end

    assign req_live   = req && rst;
    assign bank_idx   = BYPASS ? addr[IDX_HI:2] : lat_idx;
    assign bank_wdata = BYPASS ? wdata : lat_wdata;
    assign cur_wen    = BYPASS ? wen : lat_wen;

`ifdef DMEM_ALIGN_CHK_EN
    logic [1:0] lat_lo;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lat_lo <= 2'b00;
        end else if (accept) begin
            lat_lo <= addr[1:0];
        end
    end

    assign chk_err = !align_ok(cur_wen, BYPASS ? addr[1:0] : lat_lo);
`else
    assign chk_err = 1'b0;
`endif

    // Upper address bits alias; byte offset only matters to the alignment check.
    assign unused_addr = ^{addr[31:IDX_HI+1], addr[1:0]};

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        accept    = 1'b0;
        stall     = 1'b0;
        rdata     = '0;
        addr_err  = 1'b0;
        bank_we   = WEN_NONE;
        if (BYPASS) begin
            if (req_live) begin
                addr_err = chk_err;
                bank_we  = chk_err ? WEN_NONE : cur_wen;
                rdata    = lane_merge(bank_rdata, bank_wdata, bank_we);
            end
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_live) begin
                        accept    = 1'b1;
                        stall     = 1'b1;
                        cnt_nxt   = CNT_LOAD;
                        state_nxt = (WAIT_CYCLES == 1) ? ST_DONE : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    stall   = 1'b1;
                    cnt_nxt = cnt - CNT_W'(1);
                    if (cnt < CNT_W'(2)) begin
                        state_nxt = ST_DONE;
                    end
                end
                ST_DONE: begin
                    addr_err  = chk_err;
                    bank_we   = chk_err ? WEN_NONE : cur_wen;
                    rdata     = lane_merge(bank_rdata, bank_wdata, bank_we);
                    state_nxt = ST_IDLE;
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    dmem_bank #(
        .ADDR_W (ADDR_W)
    ) u_bank (
        .clk   (clk),
        .idx   (bank_idx),
        .we    (bank_we),
        .wdata (bank_wdata),
        .rdata (bank_rdata)
    );

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: a stalling instance (N=2) and a bypass instance (N=0)
// compared against a word-array reference model; DMEM_ALIGN_CHK_EN adds the misalignment cases.
module tb_dmem_responder;

    localparam int unsigned NW    = 2;
    localparam int unsigned DEPTH = 256;
`ifdef DMEM_ALIGN_CHK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        req, req0;
    logic [31:0] addr, addr0, wdata, wdata0;
    logic [3:0]  wen, wen0;
    logic [31:0] rdata, rdata0;
    logic        stall, stall0, addr_err, addr_err0;

    logic [31:0] model  [DEPTH];
    logic [31:0] model0 [DEPTH];

    int unsigned n_assert = 0;
    int unsigned n_fail   = 0;

    dmem_responder #(.ADDR_W(8), .WAIT_CYCLES(NW)) u_dut (
        .clk(clk), .rst(rst), .req(req), .addr(addr), .wdata(wdata), .wen(wen),
        .rdata(rdata), .stall(stall), .addr_err(addr_err)
    );

    dmem_responder #(.ADDR_W(8), .WAIT_CYCLES(0)) u_byp (
        .clk(clk), .rst(rst), .req(req0), .addr(addr0), .wdata(wdata0), .wen(wen0),
        .rdata(rdata0), .stall(stall0), .addr_err(addr_err0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_assert++;
        assert (got === want) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, want);
        end
    endtask

    // Expected word after a strobed write, built from a byte mask.
    function automatic logic [31:0] ref_merge(input logic [31:0] old, input logic [31:0] d,
                                              input logic [3:0] w);
        logic [31:0] mask;
        mask = {{8{w[3]}}, {8{w[2]}}, {8{w[1]}}, {8{w[0]}}};
        return (old & ~mask) | (d & mask);
    endfunction

    function automatic bit legal(input logic [31:0] a, input logic [3:0] w);
        int unsigned lo;
        bit ok;
        lo = a % 4;
        if (w == 4'b0000)                     ok = 1'b1;
        else if (w == 4'b1111)                ok = (lo == 0);
        else if (w == 4'b0011 || w == 4'b1100) ok = (lo % 2 == 0);
        else if ($countones(w) == 1)          ok = (w == 4'(1 << lo));
        else                                  ok = 1'b0;
        return !CHK || ok;
    endfunction

    function automatic logic [31:0] pool_addr();
        return ($urandom << 10) | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
    endfunction

    // One transaction on the stalling instance; rd returns rdata seen when stall drops.
    task automatic xact(input logic [31:0] a, input logic [31:0] d, input logic [3:0] w,
                        input bit hold, output logic [31:0] rd);
        int unsigned idx;
        bit ok;
        logic [31:0] want;
        idx  = (a / 4) % DEPTH;
        ok   = legal(a, w);
        want = ok ? ref_merge(model[idx], d, w) : model[idx];
        @(posedge clk); #1;
        req = 1'b1; addr = a; wdata = d; wen = w;
        for (int c = 0; c < NW; c++) begin
            @(negedge clk);
            chk("stall_hi", 32'(stall), 32'd1);
            chk("err_wait", 32'(addr_err), 32'd0);
            @(posedge clk); #1;
            if (!hold) begin
                req = 1'($urandom); addr = $urandom; wdata = $urandom; wen = 4'($urandom);
            end
        end
        @(negedge clk);
        chk("stall_lo", 32'(stall), 32'd0);
        chk("rdata", rdata, want);
        chk("addr_err", 32'(addr_err), 32'(!ok));
        rd = rdata;
        model[idx] = want;
    endtask

    task automatic idle_n();
        @(posedge clk); #1;
        req = 1'b0;
        @(negedge clk);
        chk("idle_stall", 32'(stall), 32'd0);
        chk("idle_rdata", rdata, 32'd0);
    endtask

    // One request on the zero-latency instance; it commits at the following edge.
    task automatic byp_op(input logic [31:0] a, input logic [31:0] d, input logic [3:0] w);
        int unsigned idx;
        bit ok;
        logic [31:0] want;
        idx  = (a / 4) % DEPTH;
        ok   = legal(a, w);
        want = ok ? ref_merge(model0[idx], d, w) : model0[idx];
        @(posedge clk); #1;
        req0 = 1'b1; addr0 = a; wdata0 = d; wen0 = w;
        @(negedge clk);
        chk("byp_stall", 32'(stall0), 32'd0);
        chk("byp_rdata", rdata0, want);
        chk("byp_err", 32'(addr_err0), 32'(!ok));
        model0[idx] = want;
    endtask

    initial begin
        logic [31:0] rd;
        logic [31:0] prior;
        rst = 1'b0;
        req = 1'b0; addr = '0; wdata = '0; wen = '0;
        req0 = 1'b0; addr0 = '0; wdata0 = '0; wen0 = '0;
        #2;
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_err", 32'(addr_err), 32'd0);
        chk("rst_byp_rdata", rdata0, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        for (int i = 0; i < 16; i++) xact(32'(i * 4), $urandom, 4'hF, 1'b0, rd);
        idle_n();

        // Full-word store then load.
        xact(32'h10, 32'hDEADBEEF, 4'hF, 1'b0, rd);
        xact(32'h10, 32'h0, 4'h0, 1'b0, rd);
        chk("t1_load", rd, 32'hDEADBEEF);

        // Byte-lane merges.
        xact(32'h20, 32'h11223344, 4'hF, 1'b0, rd);
        xact(32'h20, 32'h000000AA, 4'b0001, 1'b0, rd);
        xact(32'h20, 32'h0, 4'h0, 1'b0, rd);
        chk("t2_byte0", rd, 32'h112233AA);
        xact(32'h20, 32'hBBCC0000, 4'b1100, 1'b0, rd);
        xact(32'h20, 32'h0, 4'h0, 1'b0, rd);
        chk("t2_half_hi", rd, 32'hBBCC33AA);

        // Back-to-back with req held high.
        xact(32'h10, 32'hA5A50F0F, 4'hF, 1'b1, rd);
        xact(32'h10, 32'h0, 4'h0, 1'b1, rd);
        chk("t3_b2b", rd, 32'hA5A50F0F);

        // Aliasing above the word index.
        xact(32'h400, 32'h12345678, 4'hF, 1'b0, rd);
        xact(32'h000, 32'h0, 4'h0, 1'b0, rd);
        chk("t5_alias", rd, 32'h12345678);
        idle_n();

        // Reset during WAIT drops the pending store.
        prior = model[12];
        @(posedge clk); #1;
        req = 1'b1; addr = 32'h30; wdata = 32'h55555555; wen = 4'hF;
        @(posedge clk); #1;
        req = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk("t4_stall", 32'(stall), 32'd0);
        chk("t4_rdata", rdata, 32'd0);
        @(posedge clk); #1 rst = 1'b1;
        xact(32'h30, 32'h0, 4'h0, 1'b0, rd);
        chk("t4_prior", rd, prior);

`ifdef DMEM_ALIGN_CHK_EN
        xact(32'h40, 32'hCAFEF00D, 4'hF, 1'b0, rd);
        xact(32'h42, 32'h12345678, 4'hF, 1'b0, rd);
        xact(32'h40, 32'h0, 4'h0, 1'b0, rd);
        chk("t6_unchanged", rd, 32'hCAFEF00D);
        xact(32'h42, 32'h00AB0000, 4'b0100, 1'b0, rd);
        xact(32'h40, 32'h0, 4'h0, 1'b0, rd);
        chk("t6_byte2", rd, 32'hCAABF00D);
`endif

        for (int i = 0; i < 40; i++) begin
            xact(pool_addr(), $urandom, 4'($urandom_range(0, 15)), 1'($urandom), rd);
        end
        idle_n();

        for (int i = 0; i < 16; i++) byp_op(32'(i * 4), $urandom, 4'hF);
        for (int i = 0; i < 30; i++) byp_op(pool_addr(), $urandom, 4'($urandom_range(0, 15)));
        @(posedge clk); #1;
        req0 = 1'b0;
        @(negedge clk);
        chk("byp_idle_rdata", rdata0, 32'd0);
        chk("byp_idle_stall", 32'(stall0), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
